ttt_move_driver: RTL

- Autonomous button-side driver for the tic_tac_toe board: takes a target cell index (0-8, row-major) and issues timed BtnU/BtnD/BtnL/BtnR pulses until the board's cursor I equals the target, then pulses BtnC to place a mark.
- Drives the same button inputs a human uses and closes the loop on the board's I and PlayerMoved outputs.
- Used for self-play, demo mode and regression stimulus in place of hand-coded button sequences.

---
 rtl/ttt_pkg.sv | 78 +++++++
 rtl/ttt_move_driver_if.sv | 27 ++
 rtl/ttt_btn_pulser.sv | 93 +++++++++
 rtl/ttt_move_driver.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe move driver: cell indices, button
// selects, error codes, FSM states and the row/column lookup helpers.
package ttt_pkg;

  localparam logic [3:0] CELL_0   = 4'd0;
  localparam logic [3:0] CELL_1   = 4'd1;
  localparam logic [3:0] CELL_2   = 4'd2;
  localparam logic [3:0] CELL_3   = 4'd3;
  localparam logic [3:0] CELL_4   = 4'd4;
  localparam logic [3:0] CELL_5   = 4'd5;
  localparam logic [3:0] CELL_6   = 4'd6;
  localparam logic [3:0] CELL_7   = 4'd7;
  localparam logic [3:0] CELL_8   = 4'd8;
  localparam logic [3:0] MAX_CELL = CELL_8;

  typedef enum logic [2:0] {
    BTN_NONE = 3'd0,
    BTN_U    = 3'd1,
    BTN_D    = 3'd2,
    BTN_L    = 3'd3,
    BTN_R    = 3'd4,
    BTN_C    = 3'd5
  } btn_sel_t;

  // Bit positions inside the one-hot button vector
  localparam int unsigned BIT_U = 32'd0;
  localparam int unsigned BIT_D = 32'd1;
  localparam int unsigned BIT_L = 32'd2;
  localparam int unsigned BIT_R = 32'd3;
  localparam int unsigned BIT_C = 32'd4;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_BAD_TARGET = 2'd1;
  localparam logic [1:0] ERR_NO_CURSOR  = 2'd2;
  localparam logic [1:0] ERR_NOT_PLACED = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_DECIDE  = 4'd1,
    S_PRESS   = 4'd2,
    S_RELEASE = 4'd3,
    S_WAIT_I  = 4'd4,
    S_FIRE    = 4'd5,
    S_WAIT_PM = 4'd6,
    S_DONE    = 4'd7,
    S_ERR     = 4'd8
  } move_state_t;

  function automatic logic [1:0] row_of(input logic [3:0] idx);
    case (idx)
      CELL_0, CELL_1, CELL_2: row_of = 2'd0;
      CELL_3, CELL_4, CELL_5: row_of = 2'd1;
      CELL_6, CELL_7, CELL_8: row_of = 2'd2;
      default:                row_of = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] col_of(input logic [3:0] idx);
    case (idx)
      CELL_0, CELL_3, CELL_6: col_of = 2'd0;
      CELL_1, CELL_4, CELL_7: col_of = 2'd1;
      CELL_2, CELL_5, CELL_8: col_of = 2'd2;
      default:                col_of = 2'd0;
    endcase
  endfunction

  function automatic logic [4:0] btn_onehot(input btn_sel_t sel);
    case (sel)
      BTN_U:   btn_onehot = 5'b00001;
      BTN_D:   btn_onehot = 5'b00010;
      BTN_L:   btn_onehot = 5'b00100;
      BTN_R:   btn_onehot = 5'b01000;
      BTN_C:   btn_onehot = 5'b10000;
      default: btn_onehot = 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/ttt_move_driver_if.sv
// Bundle of the driver's request/status signals and the board-side button
// and feedback signals; master is the driver, slave is the host/board side.
interface ttt_move_driver_if;
  logic       start;
  logic [3:0] target;
  logic [3:0] I;
  logic       PlayerMoved;
  logic       BtnL;
  logic       BtnR;
  logic       BtnU;
  logic       BtnD;
  logic       BtnC;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  modport master (
    input  start, target, I, PlayerMoved,
    output BtnL, BtnR, BtnU, BtnD, BtnC, busy, done, error, err_code
  );

  modport slave (
    output start, target, I, PlayerMoved,
    input  BtnL, BtnR, BtnU, BtnD, BtnC, busy, done, error, err_code
  );
endinterface

// File: rtl/ttt_btn_pulser.sv
// Produces one registered one-hot button press: HOLD_CYCLES high, then
// GAP_CYCLES low, then a one-cycle finished strobe.
module ttt_btn_pulser
  import ttt_pkg::*;
#(
  parameter int HOLD_CYCLES = 10,
  parameter int GAP_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  btn_sel_t   sel,
  output logic [4:0] btn,
  output logic       in_gap,
  output logic       fin
);

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_HOLD = 2'd1,
    P_GAP  = 2'd2
  } pulse_state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

  pulse_state_t state_r, state_s;
  logic [7:0]   cnt_r, cnt_s;
  logic [4:0]   btn_r, btn_s;
  logic         fin_r, fin_s;

  // Next-state and next-output logic of the press timer
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    btn_s   = btn_r;
    fin_s   = 1'b0;
    case (state_r)
      P_IDLE: begin
        if (go) begin
          state_s = P_HOLD;
          cnt_s   = 8'd0;
          btn_s   = btn_onehot(sel);
        end else begin
          btn_s   = 5'd0;
        end
      end
      P_HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          state_s = P_GAP;
          cnt_s   = 8'd0;
          btn_s   = 5'd0;
        end else begin
          cnt_s   = cnt_r + 8'd1;
        end
      end
      P_GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_s = P_IDLE;
          cnt_s   = 8'd0;
          fin_s   = 1'b1;
        end else begin
          cnt_s   = cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = P_IDLE;
        cnt_s   = 8'd0;
        btn_s   = 5'd0;
      end
    endcase
  end

  // State, counter and registered button outputs; reset drops buttons at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= P_IDLE;
      cnt_r   <= 8'd0;
      btn_r   <= 5'd0;
      fin_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      btn_r   <= btn_s;
      fin_r   <= fin_s;
    end
  end

  assign btn    = btn_r;
  assign fin    = fin_r;
  assign in_gap = (state_r == P_GAP);

endmodule

// File: rtl/ttt_move_driver.sv
// Walks the board cursor to a target cell with timed button presses, row
// first, then presses the centre button and waits for the placement ack.
module ttt_move_driver
  import ttt_pkg::*;
#(
  parameter int HOLD_CYCLES    = 10,
  parameter int GAP_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                Clk,
  input logic                reset,
  ttt_move_driver_if.master  bus
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  move_state_t state_r, state_s;
  logic [3:0]  tgt_r, tgt_s;
  logic [3:0]  i_before_r, i_before_s;
  logic [7:0]  tmo_r, tmo_s;
  logic        pm_seen_r, pm_seen_s;
  logic [1:0]  err_code_r, err_code_s;
  logic        busy_r, done_r, error_r;
  logic        go_s;
  btn_sel_t    sel_s;
  logic [4:0]  btn_s;
  logic        in_gap_s, fin_s;

  ttt_btn_pulser #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) u_pulser (
    .clk    (Clk),
    .reset  (reset),
    .go     (go_s),
    .sel    (sel_s),
    .btn    (btn_s),
    .in_gap (in_gap_s),
    .fin    (fin_s)
  );

  // Move sequencing: pick the next correction, press it, wait for the cursor
  always_comb begin
    state_s    = state_r;
    tgt_s      = tgt_r;
    i_before_s = i_before_r;
    tmo_s      = tmo_r;
    pm_seen_s  = pm_seen_r;
    err_code_s = err_code_r;
    go_s       = 1'b0;
    sel_s      = BTN_NONE;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          tgt_s = bus.target;
          if (bus.target > MAX_CELL) begin
            err_code_s = ERR_BAD_TARGET;
            state_s    = S_ERR;
          end else begin
            err_code_s = ERR_NONE;
            state_s    = S_DECIDE;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_DECIDE: begin
        go_s       = 1'b1;
        i_before_s = bus.I;
        tmo_s      = 8'd0;
        pm_seen_s  = 1'b0;
        state_s    = S_PRESS;
        if (row_of(bus.I) < row_of(tgt_r)) begin
          sel_s = BTN_D;
        end else if (row_of(bus.I) > row_of(tgt_r)) begin
          sel_s = BTN_U;
        end else if (col_of(bus.I) < col_of(tgt_r)) begin
          sel_s = BTN_R;
        end else if (col_of(bus.I) > col_of(tgt_r)) begin
          sel_s = BTN_L;
        end else begin
          sel_s   = BTN_C;
          state_s = S_FIRE;
        end
      end
      S_PRESS: begin
        if (in_gap_s) begin
          state_s = S_RELEASE;
        end else begin
          state_s = S_PRESS;
        end
      end
      S_RELEASE: begin
        if (fin_s) begin
          state_s = S_WAIT_I;
          tmo_s   = 8'd0;
        end else begin
          state_s = S_RELEASE;
        end
      end
      S_WAIT_I: begin
        if (bus.I != i_before_r) begin
          state_s = S_DECIDE;
        end else if (tmo_r == TMO_LAST) begin
          err_code_s = ERR_NO_CURSOR;
          state_s    = S_ERR;
        end else begin
          tmo_s = tmo_r + 8'd1;
        end
      end
      S_FIRE: begin
        // An ack arriving while BtnC is still held or gapping is remembered
        pm_seen_s = pm_seen_r | bus.PlayerMoved;
        if (fin_s) begin
          state_s = S_WAIT_PM;
          tmo_s   = 8'd0;
        end else begin
          state_s = S_FIRE;
        end
      end
      S_WAIT_PM: begin
        if (pm_seen_r || bus.PlayerMoved) begin
          state_s = S_DONE;
        end else if (tmo_r == TMO_LAST) begin
          err_code_s = ERR_NOT_PLACED;
          state_s    = S_ERR;
        end else begin
          tmo_s = tmo_r + 8'd1;
        end
      end
      S_DONE:  state_s = S_IDLE;
      S_ERR:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Control state and registered status outputs derived from the next state
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      tgt_r      <= 4'd0;
      i_before_r <= 4'd0;
      tmo_r      <= 8'd0;
      pm_seen_r  <= 1'b0;
      err_code_r <= ERR_NONE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      tgt_r      <= tgt_s;
      i_before_r <= i_before_s;
      tmo_r      <= tmo_s;
      pm_seen_r  <= pm_seen_s;
      err_code_r <= err_code_s;
      busy_r     <= (state_s != S_IDLE) && (state_s != S_DONE) && (state_s != S_ERR);
      done_r     <= (state_s == S_DONE);
      error_r    <= (state_s == S_ERR);
    end
  end

  assign bus.BtnU     = btn_s[BIT_U];
  assign bus.BtnD     = btn_s[BIT_D];
  assign bus.BtnL     = btn_s[BIT_L];
  assign bus.BtnR     = btn_s[BIT_R];
  assign bus.BtnC     = btn_s[BIT_C];
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.error    = error_r;
  assign bus.err_code = err_code_r;

endmodule
